ins_dec_pipe: RTL and testbench

Parametrised, registered instruction-decode stage for the CPU core. Splits an instruction word into control and field outputs, holds them in an output register with a valid/ready handshake, and stalls on read-after-write hazards against in-flight register writes. Sits between instruction fetch and the register-file/ALU stage.

---
 rtl/ins_dec_pipe.sv | 124 ++++++++++++
 tb/tb_ins_dec_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_dec_pipe.sv
// ins_dec_pipe: registered instruction-decode stage with valid/ready handshake and an
// optional read-after-write scoreboard.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ins_valid, ins    incoming instruction word (IW = 4*RA+3 bits)
//   ins_ready         stage accepts ins this cycle
//   dec_valid         decoded outputs valid
//   dec_ready         downstream accepts decoded outputs
//   sel_data, write_en, alu_op            registered control bits
//   sel_a, sel_b, sel_w                   registered register selects (RA bits)
//   imm, jmp                              registered immediate / jump target (2*RA bits)
//   stall             RAW hazard currently blocking ins
//
// Configuration macro: INS_DEC_HAZARD_EN
//   defined   -> per-register busy counters and hazard stall are built
//   undefined -> no scoreboard, stall tied low

module ins_dec_pipe #(
    parameter int unsigned RA     = 2,
    parameter int unsigned WB_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ins_valid,
    input  logic [4*RA+2:0]   ins,
    output logic              ins_ready,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic              sel_data,
    output logic              write_en,
    output logic              alu_op,
    output logic [RA-1:0]     sel_a,
    output logic [RA-1:0]     sel_b,
    output logic [RA-1:0]     sel_w,
    output logic [2*RA-1:0]   imm,
    output logic [2*RA-1:0]   jmp,
    output logic              stall
);

    localparam int unsigned IW   = 4 * RA + 3;
    localparam int unsigned NREG = 1 << RA;

    // Combinational field split of the incoming word.
    logic [2:0]      op_in;
    logic [RA-1:0]   sel_a_in, sel_b_in, sel_w_in;
    logic [2*RA-1:0] imm_in, jmp_in;
    logic            write_en_in;
    logic            hazard;
    logic            capture;

    assign op_in       = ins[IW-1:IW-3];
    assign sel_b_in    = ins[RA-1:0];
    assign sel_a_in    = ins[2*RA-1:RA];
    assign sel_w_in    = ins[3*RA-1:2*RA];
    assign imm_in      = ins[2*RA-1:0];
    assign jmp_in      = ins[4*RA-1:2*RA];
    assign write_en_in = !((op_in == 3'b011) || (op_in == 3'b100));

    assign ins_ready = (!dec_valid || dec_ready) && !hazard;
    assign stall     = hazard;
    assign capture   = ins_valid && ins_ready;

    // Output register: fields load only on capture and otherwise hold, even after
    // the downstream has consumed them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid <= 1'b0;
            sel_data  <= 1'b0;
            write_en  <= 1'b0;
            alu_op    <= 1'b0;
            sel_a     <= '0;
            sel_b     <= '0;
            sel_w     <= '0;
            imm       <= '0;
            jmp       <= '0;
        end else if (capture) begin
            dec_valid <= 1'b1;
            sel_data  <= op_in[1];
            write_en  <= write_en_in;
            alu_op    <= op_in[0];
            sel_a     <= sel_a_in;
            sel_b     <= sel_b_in;
            sel_w     <= sel_w_in;
            imm       <= imm_in;
            jmp       <= jmp_in;
        end else if (dec_valid && dec_ready) begin
            dec_valid <= 1'b0;
        end
    end

`ifdef INS_DEC_HAZARD_EN
    logic [3:0] busy_q [NREG];
    logic       reads_in;
    logic       freeze;

    // op[1]=0 instructions read both sel_a and sel_b.
    assign reads_in = !op_in[1];
    // A held, unaccepted result means the pipe behind us is not advancing.
    assign freeze   = dec_valid && !dec_ready;
    assign hazard   = ins_valid && reads_in &&
                      ((busy_q[sel_a_in] != 4'd0) || (busy_q[sel_b_in] != 4'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                busy_q[i] <= 4'd0;
            end
        end else if (!freeze) begin
            for (int i = 0; i < NREG; i++) begin
                // A fresh write reload takes priority over the decrement.
                if (capture && write_en_in && (sel_w_in == RA'(i))) begin
                    busy_q[i] <= 4'(WB_LAT);
                end else if (busy_q[i] != 4'd0) begin
                    busy_q[i] <= busy_q[i] - 4'd1;
                end
            end
        end
    end
`else
    assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_ins_dec_pipe.sv
// Self-checking bench for ins_dec_pipe (RA=2, WB_LAT=2): directed decode table, hand-written
// hazard/backpressure/reset sequences, and randomized traffic against a reference model.
// Expectations follow the INS_DEC_HAZARD_EN setting the bench is compiled with.

module tb_ins_dec_pipe;

    localparam int unsigned RA     = 2;
    localparam int unsigned WB_LAT = 2;
`ifdef INS_DEC_HAZARD_EN
    localparam bit HAZ_EN = 1'b1;
`else
    localparam bit HAZ_EN = 1'b0;
`endif

    typedef struct packed {
        logic       sd;
        logic       we;
        logic       alu;
        logic [1:0] w;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] imm;
        logic [3:0] jmp;
    } dec_t;

    typedef struct {
        logic [10:0] ins;
        dec_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ins_valid;
    logic [10:0] ins;
    logic        ins_ready;
    logic        dec_valid;
    logic        dec_ready;
    logic        sel_data, write_en, alu_op;
    logic [1:0]  sel_a, sel_b, sel_w;
    logic [3:0]  imm, jmp;
    logic        stall;

    int checks = 0;
    int errors = 0;

    ins_dec_pipe #(.RA(RA), .WB_LAT(WB_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ins_valid (ins_valid),
        .ins       (ins),
        .ins_ready (ins_ready),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .sel_data  (sel_data),
        .write_en  (write_en),
        .alu_op    (alu_op),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .sel_w     (sel_w),
        .imm       (imm),
        .jmp       (jmp),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    dec_t dut_fields;
    assign dut_fields = dec_t'({sel_data, write_en, alu_op, sel_w, sel_a, sel_b, imm, jmp});

    // A result the downstream has not taken must stay valid and unchanged.
    property p_bp_hold;
        @(posedge clk) disable iff (!rst_n)
            (dec_valid && !dec_ready) |=> (dec_valid && $stable(dut_fields));
    endproperty
    a_bp_hold: assert property (p_bp_hold);

    // ---------------- reference model ----------------
    // Busy tracking by "advancing cycles": a register written at tick t is busy until
    // WB_LAT further non-frozen cycles have elapsed.
    logic m_valid;
    dec_t m_out;
    int   m_tick;
    int   m_issue [4];

    function automatic dec_t decode(input logic [10:0] i);
        dec_t d;
        logic [2:0] op;
        op    = i[10:8];
        d.sd  = op[1];
        d.alu = op[0];
        d.we  = !(op == 3'b011 || op == 3'b100);
        d.b   = i[1:0];
        d.a   = i[3:2];
        d.w   = i[5:4];
        d.imm = i[3:0];
        d.jmp = i[7:4];
        return d;
    endfunction

    function automatic dec_t mk(input logic sd, input logic we, input logic alu,
                                input logic [1:0] w, input logic [1:0] a, input logic [1:0] b,
                                input logic [3:0] im, input logic [3:0] jp);
        dec_t d;
        d = '{sd: sd, we: we, alu: alu, w: w, a: a, b: b, imm: im, jmp: jp};
        return d;
    endfunction

    function automatic bit busy(input logic [1:0] r);
        return (m_tick - m_issue[r]) < int'(WB_LAT);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_out   = '0;
        m_tick  = 0;
        for (int r = 0; r < 4; r++) m_issue[r] = -1000;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    dec_t got;
    logic got_v;

    // One clock: drive at negedge, compare just after, then advance the model.
    task automatic cycle(input logic iv, input logic [10:0] i, input logic dr,
                         output logic acc);
        bit   haz, rdy, frz, cap;
        dec_t d;
        @(negedge clk);
        ins_valid = iv;
        ins       = i;
        dec_ready = dr;
        #1;
        d   = decode(i);
        haz = HAZ_EN && iv && !d.sd && (busy(d.a) || busy(d.b));
        rdy = (!m_valid || dr) && !haz;
        chk("dec_valid", {31'd0, dec_valid}, {31'd0, m_valid});
        chk("dec_fields", 32'(dut_fields), 32'(m_out));
        chk("ins_ready", {31'd0, ins_ready}, {31'd0, rdy});
        chk("stall", {31'd0, stall}, {31'd0, haz});
        acc   = iv && ins_ready;
        got   = dut_fields;
        got_v = dec_valid;
        frz = m_valid && !dr;
        cap = iv && rdy;
        if (!frz) m_tick++;
        if (cap) begin
            m_out   = d;
            m_valid = 1'b1;
            if (d.we) m_issue[d.w] = m_tick;
        end else if (m_valid && dr) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 11'h000, 1'b1, acc);
    endtask

    // Hold an instruction valid until the DUT takes it; count refused cycles.
    task automatic issue_count(input logic [10:0] i, input int exp_stalls, input string name);
        int   n;
        logic acc;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, i, 1'b1, acc);
            if (acc) break;
            n++;
        end
        chk(name, 32'(n), 32'(exp_stalls));
    endtask

    vec_t vecs [6];

    initial begin
        logic acc;

        vecs[0] = '{11'h01B, mk(1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 2'd3, 4'hB, 4'h1)};
        vecs[1] = '{11'h224, mk(1'b1, 1'b1, 1'b0, 2'd2, 2'd1, 2'd0, 4'h4, 4'h2)};
        vecs[2] = '{11'h3C6, mk(1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 2'd2, 4'h6, 4'hC)};
        vecs[3] = '{11'h4A5, mk(1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd1, 4'h5, 4'hA)};
        vecs[4] = '{11'h7FF, mk(1'b1, 1'b1, 1'b1, 2'd3, 2'd3, 2'd3, 4'hF, 4'hF)};
        vecs[5] = '{11'h1E1, mk(1'b0, 1'b1, 1'b1, 2'd2, 2'd0, 2'd1, 4'h1, 4'hE)};

        // Reset state.
        rst_n     = 1'b0;
        ins_valid = 1'b0;
        ins       = '0;
        dec_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_fields", 32'(dut_fields), 32'd0);
        chk("rst_ins_ready", {31'd0, ins_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Decode table.
        foreach (vecs[v]) begin
            idle(3);
            cycle(1'b1, vecs[v].ins, 1'b1, acc);
            chk("tbl_accept", {31'd0, acc}, 32'd1);
            cycle(1'b0, 11'h000, 1'b1, acc);
            chk("tbl_valid", {31'd0, got_v}, 32'd1);
            chk("tbl_fields", 32'(got), 32'(vecs[v].exp));
        end

        // RAW: reader of r1 right after its producer.
        idle(3);
        cycle(1'b1, 11'h01B, 1'b1, acc);
        issue_count(11'h024, HAZ_EN ? int'(WB_LAT) : 0, "raw_stalls");

        // Immediate op after producer: no read, no stall.
        idle(3);
        cycle(1'b1, 11'h01B, 1'b1, acc);
        issue_count(11'h224, 0, "imm_no_stall");

        // Non-writing op targeting r1, then a reader of r1.
        idle(3);
        cycle(1'b1, 11'h310, 1'b1, acc);
        issue_count(11'h024, 0, "nowrite_no_stall");

        // Backpressure: result held, counter frozen, then full stall after release.
        idle(3);
        cycle(1'b1, 11'h01B, 1'b1, acc);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 11'h024, 1'b0, acc);
            chk("bp_held", 32'(got), 32'(decode(11'h01B)));
            chk("bp_no_accept", {31'd0, acc}, 32'd0);
        end
        issue_count(11'h024, HAZ_EN ? int'(WB_LAT) : 0, "bp_release_stalls");

        // Asynchronous reset mid-operation drops held result and scoreboard.
        idle(3);
        cycle(1'b1, 11'h01B, 1'b1, acc);
        @(negedge clk);
        ins_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_valid", {31'd0, dec_valid}, 32'd0);
        chk("mid_rst_fields", 32'(dut_fields), 32'd0);
        chk("mid_rst_ready", {31'd0, ins_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        issue_count(11'h024, 0, "post_rst_no_stall");

        // Randomized traffic.
        idle(3);
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom % 4) != 0, 11'($urandom), ($urandom % 4) != 0, acc);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
